// File: rtl/mem_rsp_ctrl.sv
// mem_rsp_ctrl: single-outstanding cache-line backing store.
// Each accepted request is answered after LATENCY cycles. A load returns
// one line. A store writes its line in the response cycle.
// Optional feature: define MEM_RSP_ADDR_CHECK_EN to flag out-of-range line indices.
// Without it, indices wrap modulo MEM_LINES.

`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif

package mem_rsp_pkg;
  typedef struct packed {
    logic [31:0]                   addr;
    logic                          is_store;
    logic [`DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;
endpackage

// Handshake: a request transfers on a rising edge where req_valid_miss and
// mem_ready are both high. The requester keeps req_valid_miss and
// req_info_miss stable until that happens. rsp_valid_miss is a single-cycle
// pulse with no back-pressure. rsp_data_miss is zero whenever it is low.
module mem_rsp_ctrl
  import mem_rsp_pkg::*;
#(
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid_miss,
  input  memory_request_t               req_info_miss,
  output logic                          mem_ready,
  output logic                          rsp_valid_miss,
  output logic [`DCACHE_LINE_WIDTH-1:0] rsp_data_miss,
  output logic                          rsp_error,
  output logic [1:0]                    dbg_state
);

  localparam int LINE_W = `DCACHE_LINE_WIDTH;
  localparam int OFF_W  = 4;
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  // BUSY covers LATENCY-1 cycles, so the counter counts LATENCY-2 down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  memory_request_t   req_q;
  logic [LINE_W-1:0] mem_array [MEM_LINES];
  logic              accept;
  logic [IDX_W-1:0]  line_idx;
  logic              in_range;
  logic              do_write;
  logic              unused_addr_bits;

  assign accept    = req_valid_miss & mem_ready;
  assign line_idx  = req_q.addr[OFF_W +: IDX_W];
  assign dbg_state = state_q;

  // Offset bits and, without the range check, the high index bits are not
  // needed for decoding.
  assign unused_addr_bits = ^{req_q.addr[OFF_W-1:0], req_q.addr >> (OFF_W + IDX_W)};

`ifdef MEM_RSP_ADDR_CHECK_EN
  // The full line index above the offset must fit inside the array.
  assign in_range = ((req_q.addr >> (OFF_W + IDX_W)) == 32'd0);
`else
  assign in_range = 1'b1;
`endif

  // State, counter and captured request. Reset drops any in-flight transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= req_info_miss;
    end
  end

  // Next-state logic and Moore outputs for the IDLE -> BUSY -> RESP cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_ready      = 1'b0;
    rsp_valid_miss = 1'b0;
    rsp_data_miss  = '0;
    rsp_error      = 1'b0;
    do_write       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_ready = 1'b1;
        if (req_valid_miss) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!req_q.is_store) begin
          rsp_valid_miss = 1'b1;
          if (in_range) rsp_data_miss = mem_array[line_idx];
        end else begin
          do_write = in_range;
        end
`ifdef MEM_RSP_ADDR_CHECK_EN
        rsp_error = ~in_range;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Backing store is not reset. Stores land in the response cycle.
  always_ff @(posedge clock) begin
    if (do_write) mem_array[line_idx] <= req_q.data;
  end

endmodule

// File: tb/tb_mem_rsp_ctrl.sv
// Bench for mem_rsp_ctrl. The main instance uses LATENCY=10.
// A second instance checks the LATENCY=2 boundary.
// The reference model treats memory as a plain array. It expects each
// response at acceptance cycle + LATENCY and queues expected load data.

`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif

module tb_mem_rsp_ctrl;
  import mem_rsp_pkg::*;

  localparam int W         = `DCACHE_LINE_WIDTH;
  localparam int MEM_LINES = 256;
  localparam int LATENCY   = 10;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic            req_valid_miss;
  memory_request_t req_info_miss;
  logic            mem_ready, rsp_valid_miss, rsp_error;
  logic [W-1:0]    rsp_data_miss;
  logic [1:0]      dbg_state;

  logic            req_valid2;
  memory_request_t req_info2;
  logic            ready2, rv2, err2;
  logic [W-1:0]    rd2;
  logic [1:0]      dbg2;

  mem_rsp_ctrl #(.MEM_LINES(MEM_LINES), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset(reset),
    .req_valid_miss(req_valid_miss), .req_info_miss(req_info_miss),
    .mem_ready(mem_ready), .rsp_valid_miss(rsp_valid_miss),
    .rsp_data_miss(rsp_data_miss), .rsp_error(rsp_error), .dbg_state(dbg_state)
  );

  mem_rsp_ctrl #(.MEM_LINES(MEM_LINES), .LATENCY(2)) dut2 (
    .clock(clock), .reset(reset),
    .req_valid_miss(req_valid2), .req_info_miss(req_info2),
    .mem_ready(ready2), .rsp_valid_miss(rv2),
    .rsp_data_miss(rd2), .rsp_error(err2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard / model state ----------------
  int           vec_count  = 0;
  int           miss_count = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem [MEM_LINES];
  int           cyc = 0;
  bit           pend = 0;
  int           pend_cyc, pend_idx;
  bit           pend_st, pend_oor;
  logic [W-1:0] pend_data;
  bit           want_v = 0;
  bit           want_st;
  logic [31:0]  want_addr;
  logic [W-1:0] want_data;
  logic [W-1:0] last_rsp;
  int           n_rsp = 0, n_load = 0, n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_line();
    return W'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // One clock cycle. Compare outputs against the model, then drive the held
  // request. A request is accepted in any cycle where the model says ready.
  task automatic cycle();
    bit           resp_now, exp_ready, exp_rv, exp_err;
    logic [W-1:0] exp_data;
    @(negedge clock);
    cyc++;
    resp_now  = pend && (cyc == pend_cyc + LATENCY);
    exp_ready = !pend;
    exp_rv    = resp_now && !pend_st;
    exp_err   = resp_now && pend_oor;
    exp_data  = '0;
    if (exp_rv && exp_q.size() > 0) exp_data = exp_q.pop_front();
    check("mem_ready", W'(mem_ready), W'(exp_ready));
    check("rsp_valid", W'(rsp_valid_miss), W'(exp_rv));
    check("rsp_data", rsp_data_miss, exp_data);
    check("rsp_error", W'(rsp_error), W'(exp_err));
    if (rsp_valid_miss) begin
      last_rsp = rsp_data_miss;
      n_rsp++;
    end
    if (rsp_error) n_err++;
    if (resp_now) begin
      if (pend_st && !pend_oor) model_mem[pend_idx] = pend_data;
      pend = 0;
    end
    // Driver: present the held request.
    req_valid_miss         = want_v;
    req_info_miss.addr     = want_addr;
    req_info_miss.is_store = want_st;
    req_info_miss.data     = want_data;
    if (want_v && exp_ready) begin
      pend      = 1;
      pend_cyc  = cyc;
      pend_st   = want_st;
      pend_data = want_data;
      pend_idx  = int'((want_addr >> 4) % MEM_LINES);
`ifdef MEM_RSP_ADDR_CHECK_EN
      pend_oor  = ((want_addr >> 4) >= MEM_LINES);
`else
      pend_oor  = 0;
`endif
      if (!want_st) begin
        n_load++;
        if (pend_oor) exp_q.push_back('0);
        else          exp_q.push_back(model_mem[pend_idx]);
      end
      want_v = 0;
    end
  endtask

  task automatic issue(input bit st, input logic [31:0] a, input logic [W-1:0] d);
    int n;
    n = 0;
    want_v = 1; want_st = st; want_addr = a; want_data = d;
    while (want_v && n < 50) begin
      cycle();
      n++;
    end
    if (want_v) begin
      check("accept_timeout", W'(0), W'(1));
      want_v = 0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend || want_v) && n < 100) begin
      cycle();
      n++;
    end
    if (pend || want_v) begin
      check("idle_timeout", W'(0), W'(1));
      pend = 0; want_v = 0;
    end
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] line5, line_a, pre70, d2;
    int           err_before;
    line5  = W'(128'h0123456789ABCDEF0123456789ABCDEF);
    line_a = {(W/4){4'hA}};

    reset = 1'b0;
    req_valid_miss = 1'b0; req_info_miss = '0;
    req_valid2 = 1'b0; req_info2 = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", W'(mem_ready), W'(1));
    check("rst_rsp_valid", W'(rsp_valid_miss), W'(0));
    check("rst_rsp_data", rsp_data_miss, '0);
    check("rst_rsp_error", W'(rsp_error), W'(0));
    check("rst_ready2", W'(ready2), W'(1));
    reset = 1'b1;

    // Preload every line through back-to-back stores.
    for (int i = 0; i < MEM_LINES; i++) issue(1'b1, 32'(i) << 4, rand_line());
    wait_idle();

    // Load line 5 with a known pattern.
    issue(1'b1, 32'h50, line5);
    issue(1'b0, 32'h50, '0);
    wait_idle();
    check("line5_load", last_rsp, line5);

    // Store, then load the same line at the first ready cycle.
    issue(1'b1, 32'h30, line_a);
    issue(1'b0, 32'h30, '0);
    wait_idle();
    check("store_then_load", last_rsp, line_a);

    // Random traffic. Requests are held while the DUT is busy.
    for (int n = 0; n < 600; n++) begin
      if (!want_v && $urandom_range(0, 2) != 0) begin
        want_st = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0) want_addr = $urandom();
        else want_addr = (32'($urandom_range(0, MEM_LINES - 1)) << 4) | 32'($urandom_range(0, 15));
        want_data = rand_line();
        want_v = 1;
      end
      cycle();
    end
    wait_idle();

    // Reset in the middle of a store aborts it.
    pre70 = model_mem[7];
    issue(1'b1, 32'h70, ~pre70);
    repeat (4) cycle();
    #2 reset = 1'b0;
    #1;
    check("midrst_ready", W'(mem_ready), W'(1));
    check("midrst_rsp_valid", W'(rsp_valid_miss), W'(0));
    check("midrst_rsp_data", rsp_data_miss, '0);
    pend = 0; want_v = 0; exp_q.delete();
    req_valid_miss = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    issue(1'b0, 32'h70, '0);
    wait_idle();
    check("midrst_no_write", last_rsp, pre70);

    // Line index 256: out of range with the check enabled, or aliased to line 0.
    err_before = n_err;
    last_rsp = rand_line();
    issue(1'b0, 32'h1000, '0);
    wait_idle();
`ifdef MEM_RSP_ADDR_CHECK_EN
    check("oor_error", W'(n_err - err_before), W'(1));
    check("oor_data", last_rsp, '0);
`else
    check("alias_error", W'(n_err - err_before), W'(0));
    check("alias_data", last_rsp, model_mem[0]);
`endif

    check("rsp_per_load", W'(n_rsp), W'(n_load));
    check("exp_q_empty", W'(exp_q.size()), W'(0));

    // Minimum latency: response at T+2, ready again at T+3.
    d2 = rand_line();
    @(negedge clock);
    check("l2_ready_idle", W'(ready2), W'(1));
    req_valid2 = 1'b1; req_info2.addr = 32'h10; req_info2.is_store = 1'b1; req_info2.data = d2;
    @(negedge clock);
    check("l2_st_busy", W'(ready2), W'(0));
    req_valid2 = 1'b0;
    @(negedge clock);
    check("l2_st_resp_ready", W'(ready2), W'(0));
    check("l2_st_no_rsp", W'(rv2), W'(0));
    @(negedge clock);
    check("l2_st_ready_back", W'(ready2), W'(1));
    req_valid2 = 1'b1; req_info2.is_store = 1'b0; req_info2.data = '0;
    @(negedge clock);
    check("l2_ld_busy_rsp", W'(rv2), W'(0));
    req_valid2 = 1'b0;
    @(negedge clock);
    check("l2_ld_rsp_valid", W'(rv2), W'(1));
    check("l2_ld_rsp_data", rd2, d2);
    @(negedge clock);
    check("l2_ld_ready_back", W'(ready2), W'(1));
    check("l2_ld_rsp_clear", rd2, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
